// File: rtl/traffic_phase_monitor_if.sv
// Light-controller output bus as seen by the phase monitor.
// The controller side drives phase/countdown/clear; the monitor side drives the lamp and status pins.
interface traffic_phase_monitor_if;
    logic [1:0] phase_in;
    logic [3:0] count_in;
    logic       clr_fault;
    logic       led_green;
    logic       led_yellow;
    logic       led_red;
    logic       warn;
    logic [4:0] dwell;
    logic       seq_err;
    logic       time_err;
    logic       fault;
    logic [7:0] err_cnt;

    modport master (
        output phase_in, count_in, clr_fault,
        input  led_green, led_yellow, led_red, warn, dwell,
        input  seq_err, time_err, fault, err_cnt
    );

    modport slave (
        input  phase_in, count_in, clr_fault,
        output led_green, led_yellow, led_red, warn, dwell,
        output seq_err, time_err, fault, err_cnt
    );
endinterface

// File: rtl/traffic_phase_monitor.sv
// Receives the light-controller phase bus, checks phase order and per-phase dwell,
// drives the lamps and latches a fault (flashing yellow) on any protocol violation.
module traffic_phase_monitor #(
    parameter int unsigned GREEN_TICKS  = 16,
    parameter int unsigned YELLOW_TICKS = 5,
    parameter int unsigned RED_TICKS    = 10,
    parameter int unsigned WARN_TH      = 3
) (
    input  logic                   clk_div,
    input  logic                   reset,
    traffic_phase_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0] PH_GREEN   = 2'b00;
    localparam logic [1:0] PH_YELLOW  = 2'b01;
    localparam logic [1:0] PH_RED     = 2'b10;
    localparam logic [1:0] PH_ILLEGAL = 2'b11;

    localparam logic [4:0] DWELL_MAX   = 5'd31;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [1:0] succ_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_GREEN:  nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_RED;
            PH_RED:    nxt = PH_GREEN;
            default:   nxt = PH_ILLEGAL;
        endcase
        return nxt;
    endfunction

    function automatic logic [4:0] expected_dwell(input logic [1:0] ph);
        logic [4:0] req;
        case (ph)
            PH_GREEN:  req = 5'(GREEN_TICKS);
            PH_YELLOW: req = 5'(YELLOW_TICKS);
            PH_RED:    req = 5'(RED_TICKS);
            default:   req = 5'd0;
        endcase
        return req;
    endfunction

    state_t     state_r;
    state_t     state_nx_s;
    logic [1:0] phase_r;
    logic [4:0] dwell_r;
    logic [4:0] dwell_nx_s;
    logic       led_green_r;
    logic       led_yellow_r;
    logic       led_red_r;
    logic       led_green_s;
    logic       led_yellow_s;
    logic       led_red_s;
    logic       warn_r;
    logic       warn_s;
    logic       seq_err_r;
    logic       seq_err_s;
    logic       time_err_r;
    logic       time_err_s;
    logic       fault_r;
    logic [7:0] err_cnt_r;
    logic [7:0] err_cnt_nx_s;
    logic       transition_s;
    logic       illegal_s;

    assign transition_s = (bus.phase_in != phase_r);
    assign illegal_s    = (bus.phase_in == PH_ILLEGAL);

    // Next-state and error detection; checks only run while locked onto the sequence.
    always_comb begin
        state_nx_s = state_r;
        seq_err_s  = 1'b0;
        time_err_s = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (illegal_s) begin
                    seq_err_s  = 1'b1;
                    state_nx_s = ST_FAULT;
                end else if (transition_s && (bus.phase_in == PH_GREEN)) begin
                    state_nx_s = ST_TRACK;
                end else begin
                    state_nx_s = ST_SYNC;
                end
            end
            ST_TRACK: begin
                seq_err_s  = illegal_s ||
                             (transition_s && (bus.phase_in != succ_phase(phase_r)));
                time_err_s = transition_s && (dwell_r != expected_dwell(phase_r));
                if (seq_err_s || time_err_s) begin
                    state_nx_s = ST_FAULT;
                end else begin
                    state_nx_s = ST_TRACK;
                end
            end
            ST_FAULT: begin
                // A clear arriving together with another illegal code is ignored.
                if (bus.clr_fault && !illegal_s) begin
                    state_nx_s = ST_SYNC;
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end
            default: begin
                state_nx_s = ST_SYNC;
            end
        endcase
    end

    // Dwell counter, error counter and lamp/warn values to be registered.
    always_comb begin
        dwell_nx_s   = dwell_r;
        err_cnt_nx_s = err_cnt_r;
        led_green_s  = 1'b0;
        led_yellow_s = 1'b0;
        led_red_s    = 1'b0;
        warn_s       = 1'b0;

        if (state_r == ST_FAULT) begin
            dwell_nx_s = 5'd0;
        end else if (transition_s) begin
            dwell_nx_s = 5'd1;
        end else if (dwell_r == DWELL_MAX) begin
            dwell_nx_s = DWELL_MAX;
        end else begin
            dwell_nx_s = dwell_r + 5'd1;
        end

        // A combined order+timing violation is one error event.
        if ((seq_err_s || time_err_s) && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_nx_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nx_s = err_cnt_r;
        end

        if (state_r == ST_FAULT) begin
            // fault_r still low means this is the first fault cycle: start the blink lit.
            led_yellow_s = fault_r ? ~led_yellow_r : 1'b1;
        end else begin
            case (bus.phase_in)
                PH_GREEN:  led_green_s  = 1'b1;
                PH_YELLOW: led_yellow_s = 1'b1;
                PH_RED:    led_red_s    = 1'b1;
                default:   led_green_s  = 1'b0;
            endcase
        end

        if ((state_r == ST_TRACK) && (bus.phase_in == PH_GREEN) &&
            (bus.count_in <= 4'(WARN_TH))) begin
            warn_s = 1'b1;
        end else begin
            warn_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_SYNC;
            phase_r      <= PH_RED;
            dwell_r      <= 5'd0;
            led_green_r  <= 1'b0;
            led_yellow_r <= 1'b0;
            led_red_r    <= 1'b0;
            warn_r       <= 1'b0;
            seq_err_r    <= 1'b0;
            time_err_r   <= 1'b0;
            fault_r      <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            phase_r      <= bus.phase_in;
            dwell_r      <= dwell_nx_s;
            led_green_r  <= led_green_s;
            led_yellow_r <= led_yellow_s;
            led_red_r    <= led_red_s;
            warn_r       <= warn_s;
            seq_err_r    <= seq_err_s;
            time_err_r   <= time_err_s;
            fault_r      <= (state_r == ST_FAULT);
            err_cnt_r    <= err_cnt_nx_s;
        end
    end

    assign bus.led_green  = led_green_r;
    assign bus.led_yellow = led_yellow_r;
    assign bus.led_red    = led_red_r;
    assign bus.warn       = warn_r;
    assign bus.dwell      = dwell_r;
    assign bus.seq_err    = seq_err_r;
    assign bus.time_err   = time_err_r;
    assign bus.fault      = fault_r;
    assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Directed bench for traffic_phase_monitor: a reference model pushes each cycle's expected
// outputs to a scoreboard queue, popped and compared after the clock edge.
module tb_traffic_phase_monitor;

    logic clk_div = 1'b0;
    logic reset;
    traffic_phase_monitor_if bus();

    traffic_phase_monitor dut (
        .clk_div (clk_div),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_div = ~clk_div;

    int checks = 0;
    int errors = 0;
    logic [19:0] sb_q[$];

    // Reference model state: 0 SYNC, 1 TRACK, 2 FAULT.
    int         m_st;
    logic [1:0] m_ph;
    int         m_dw;
    int         m_cnt;
    logic       m_y;
    logic       m_flt;
    logic [1:0] succ_tab [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
    int         need_tab [4] = '{16, 5, 10, 0};

    function automatic logic [19:0] observed();
        return {bus.led_green, bus.led_yellow, bus.led_red, bus.warn, bus.dwell,
                bus.seq_err, bus.time_err, bus.fault, bus.err_cnt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ph = 2'd2; m_dw = 0; m_cnt = 0; m_y = 1'b0; m_flt = 1'b0;
    endtask

    task automatic push_expected(input logic [1:0] p, input logic [3:0] c, input logic clr);
        logic tr, se, te, g, y, r, w;
        int nst, ndw;
        tr = (p != m_ph); se = 1'b0; te = 1'b0; nst = m_st;
        if (m_st == 0) begin
            if (p == 2'd3) begin se = 1'b1; nst = 2; end
            else if (tr && p == 2'd0) nst = 1;
        end else if (m_st == 1) begin
            if (tr) begin
                se = (p != succ_tab[m_ph]);
                te = (m_dw != need_tab[m_ph]);
            end
            if (se || te) nst = 2;
        end else begin
            if (clr && p != 2'd3) nst = 0;
        end
        ndw = (m_st == 2) ? 0 : (tr ? 1 : ((m_dw == 31) ? 31 : m_dw + 1));
        if (m_st == 2) begin
            g = 1'b0; r = 1'b0; y = m_flt ? ~m_y : 1'b1;
        end else begin
            g = (p == 2'd0); y = (p == 2'd1); r = (p == 2'd2);
        end
        w = (m_st == 1) && (p == 2'd0) && (c <= 4'd3);
        if ((se || te) && m_cnt < 255) m_cnt++;
        m_flt = (m_st == 2);
        m_y = y; m_dw = ndw; m_st = nst; m_ph = p;
        sb_q.push_back({g, y, r, w, 5'(m_dw), se, te, m_flt, 8'(m_cnt)});
    endtask

    task automatic cyc(input logic [1:0] p, input logic [3:0] c, input logic clr, input string tag);
        logic [19:0] e;
        bus.phase_in = p; bus.count_in = c; bus.clr_fault = clr;
        push_expected(p, c, clr);
        @(posedge clk_div); #1;
        e = sb_q.pop_front();
        chk(tag, 32'(observed()), 32'(e));
    endtask

    task automatic hold(input logic [1:0] p, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(p, 4'(n - 1 - i), 1'b0, tag);
    endtask

    initial begin
        reset = 1'b0;
        bus.phase_in = 2'd2; bus.count_in = 4'd0; bus.clr_fault = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_div);
        #1;
        chk("reset_state", 32'(observed()), 32'd0);
        reset = 1'b1;

        // 1: legal loop
        repeat (3) begin
            hold(2'd0, 16, "legal_green");
            hold(2'd1, 5, "legal_yellow");
            hold(2'd2, 10, "legal_red");
        end
        chk("legal_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("legal_fault", 32'(bus.fault), 32'd0);
        chk("legal_led_red", 32'(bus.led_red), 32'd1);

        // 2: yellow too long
        hold(2'd0, 16, "y6_green");
        hold(2'd1, 6, "y6_yellow");
        cyc(2'd2, 4'd0, 1'b0, "y6_edge");
        chk("y6_time_err", 32'(bus.time_err), 32'd1);
        chk("y6_seq_err", 32'(bus.seq_err), 32'd0);
        cyc(2'd2, 4'd0, 1'b0, "y6_f1");
        chk("y6_fault", 32'(bus.fault), 32'd1);
        chk("y6_time_err_drop", 32'(bus.time_err), 32'd0);
        chk("y6_blink1", 32'(bus.led_yellow), 32'd1);
        cyc(2'd2, 4'd0, 1'b0, "y6_f2");
        chk("y6_blink0", 32'(bus.led_yellow), 32'd0);
        cyc(2'd2, 4'd0, 1'b0, "y6_f3");
        chk("y6_blink1b", 32'(bus.led_yellow), 32'd1);
        chk("y6_err_cnt", 32'(bus.err_cnt), 32'd1);
        cyc(2'd2, 4'd0, 1'b1, "y6_clear");

        // 3: order jump green->red
        hold(2'd0, 16, "jump_green");
        cyc(2'd2, 4'd0, 1'b0, "jump_edge");
        chk("jump_seq_err", 32'(bus.seq_err), 32'd1);
        chk("jump_time_err", 32'(bus.time_err), 32'd0);
        chk("jump_err_cnt", 32'(bus.err_cnt), 32'd2);
        cyc(2'd2, 4'd0, 1'b0, "jump_f1");
        chk("jump_fault", 32'(bus.fault), 32'd1);
        cyc(2'd2, 4'd0, 1'b1, "jump_clear");
        cyc(2'd2, 4'd0, 1'b0, "jump_sync");
        chk("jump_fault_clr", 32'(bus.fault), 32'd0);
        hold(2'd0, 3, "jump_relock");
        chk("jump_relock_dwell", 32'(bus.dwell), 32'd3);
        chk("jump_relock_green", 32'(bus.led_green), 32'd1);

        // 4: illegal code with short green pending
        cyc(2'd3, 4'd0, 1'b0, "ill_edge");
        chk("ill_seq_err", 32'(bus.seq_err), 32'd1);
        chk("ill_err_cnt", 32'(bus.err_cnt), 32'd3);
        chk("ill_leds_off", 32'({bus.led_green, bus.led_yellow, bus.led_red}), 32'd0);
        cyc(2'd3, 4'd0, 1'b0, "ill_f1");
        chk("ill_blink1", 32'(bus.led_yellow), 32'd1);
        cyc(2'd3, 4'd0, 1'b1, "ill_clr_blocked");
        chk("ill_no_pulse", 32'(bus.seq_err), 32'd0);
        cyc(2'd2, 4'd0, 1'b1, "ill_clear");
        chk("ill_still_fault", 32'(bus.fault), 32'd1);
        chk("ill_err_cnt_hold", 32'(bus.err_cnt), 32'd3);
        cyc(2'd2, 4'd0, 1'b0, "ill_sync");
        chk("ill_fault_clr", 32'(bus.fault), 32'd0);

        // 5: warn near end of green
        for (int i = 0; i < 11; i++) cyc(2'd0, 4'd9, 1'b0, "warn_green");
        cyc(2'd0, 4'd5, 1'b0, "warn_c5");
        chk("warn_c5", 32'(bus.warn), 32'd0);
        cyc(2'd0, 4'd4, 1'b0, "warn_c4");
        chk("warn_c4", 32'(bus.warn), 32'd0);
        cyc(2'd0, 4'd3, 1'b0, "warn_c3");
        chk("warn_c3", 32'(bus.warn), 32'd1);
        cyc(2'd0, 4'd2, 1'b0, "warn_c2");
        chk("warn_c2", 32'(bus.warn), 32'd1);
        cyc(2'd0, 4'd1, 1'b0, "warn_c1");
        cyc(2'd1, 4'd0, 1'b0, "warn_yellow");
        chk("warn_fall", 32'(bus.warn), 32'd0);
        chk("warn_no_time_err", 32'(bus.time_err), 32'd0);
        hold(2'd1, 4, "warn_yellow_rest");
        hold(2'd2, 10, "warn_red");
        chk("warn_err_cnt", 32'(bus.err_cnt), 32'd3);

        // 6: error counter saturation, then mid-phase reset
        for (int k = 0; k < 260; k++) begin
            cyc(2'd3, 4'd0, 1'b0, "sat_err");
            cyc(2'd2, 4'd0, 1'b1, "sat_clear");
        end
        chk("sat_err_cnt", 32'(bus.err_cnt), 32'd255);
        hold(2'd0, 5, "rst_green");
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", 32'(observed()), 32'd0);
        model_reset();
        bus.phase_in = 2'd2;
        @(posedge clk_div); #1;
        chk("rst_held", 32'(observed()), 32'd0);
        reset = 1'b1;
        hold(2'd0, 4, "rst_relock");
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
